// File: rtl/tt3_sweep_ctrl.sv
// tt3_sweep_ctrl: steps a 3-input truth-table logic block through rows 000..111.
// Each row is held for SETTLE_CYCLES cycles, and the block output is sampled on
// the last of them into table_out[7-row], so a 0xDE block reads back 8'hDE.
// Optional build macro TT3_SWEEP_COMPARE_EN adds a compare against an expected word.
//
// Handshake: start is a one-cycle request that is honoured only in IDLE.
// abort ends an active sweep and has no effect outside RUN. done pulses for
// exactly one cycle (FIN) after a sweep that ran to completion. table_out is
// meaningful only while table_valid is high.
module tt3_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_out,
   output logic       drv_in1,
   output logic       drv_in2,
   output logic       drv_in3,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
   output logic       table_valid,
   output logic [1:0] dbg_state
`ifdef TT3_SWEEP_COMPARE_EN
   ,
   input  logic [7:0] expected,
   output logic       match,
   output logic [7:0] mismatch_mask
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state;
   logic [2:0]       row;
   logic [CNT_W-1:0] cnt;
   logic             sample_now;
   logic [7:0]       table_next;

`ifdef TT3_SWEEP_COMPARE_EN
   logic [7:0] expected_q;
   logic [7:0] diff;
`endif

   assign sample_now = (cnt == CNT_LAST);
   assign dbg_state  = state;

   // Table word as it will look once the current row's sample is written.
   always_comb begin
      table_next = table_out;
      table_next[3'd7 - row] = dut_out;
   end

`ifdef TT3_SWEEP_COMPARE_EN
   assign diff = table_next ^ expected_q;
`endif

   // Sweep sequencer: the state and all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         row         <= 3'd0;
         cnt         <= '0;
         drv_in1     <= 1'b0;
         drv_in2     <= 1'b0;
         drv_in3     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         table_out   <= 8'h00;
         table_valid <= 1'b0;
`ifdef TT3_SWEEP_COMPARE_EN
         expected_q    <= 8'h00;
         match         <= 1'b0;
         mismatch_mask <= 8'h00;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               busy                        <= 1'b0;
               {drv_in1, drv_in2, drv_in3} <= 3'b000;
               if (start) begin
                  state       <= S_RUN;
                  row         <= 3'd0;
                  cnt         <= '0;
                  busy        <= 1'b1;
                  table_out   <= 8'h00;
                  table_valid <= 1'b0;
`ifdef TT3_SWEEP_COMPARE_EN
                  expected_q    <= expected;
                  match         <= 1'b0;
                  mismatch_mask <= 8'h00;
`endif
               end
            end
            S_RUN: begin
               if (abort) begin
                  // The sample due in this cycle is dropped; partial bits stay.
                  state                       <= S_IDLE;
                  busy                        <= 1'b0;
                  row                         <= 3'd0;
                  cnt                         <= '0;
                  {drv_in1, drv_in2, drv_in3} <= 3'b000;
               end else if (sample_now) begin
                  table_out <= table_next;
                  cnt       <= '0;
                  if (row == 3'd7) begin
                     state                       <= S_FIN;
                     row                         <= 3'd0;
                     busy                        <= 1'b0;
                     done                        <= 1'b1;
                     table_valid                 <= 1'b1;
                     {drv_in1, drv_in2, drv_in3} <= 3'b000;
`ifdef TT3_SWEEP_COMPARE_EN
                     mismatch_mask <= diff;
                     match         <= (diff == 8'h00);
`endif
                  end else begin
                     row                         <= row + 3'd1;
                     {drv_in1, drv_in2, drv_in3} <= row + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt3_sweep_ctrl.sv
// Bench for tt3_sweep_ctrl. Instance 0 uses SETTLE_CYCLES=2 and instance 1 uses
// SETTLE_CYCLES=1. Each instance drives a behavioural truth-table block whose
// value is taken from model_tt.
module tb_tt3_sweep_ctrl;

   logic       clk = 1'b0;
   logic [1:0] rst;
   logic [1:0] start;
   logic [1:0] abort;
   logic [7:0] model_tt [2];
   logic [7:0] exp_val  [2];

   wire  [1:0] dut_out;
   wire  [2:0] drv [2];
   wire  [1:0] busy;
   wire  [1:0] done;
   wire  [1:0] tv;
   wire  [7:0] tbl [2];
   wire  [1:0] st  [2];
`ifdef TT3_SWEEP_COMPARE_EN
   wire  [1:0] match;
   wire  [7:0] mask [2];
`endif

   logic [7:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign dut_out[0] = model_tt[0][3'd7 - drv[0]];
   assign dut_out[1] = model_tt[1][3'd7 - drv[1]];

   tt3_sweep_ctrl #(.SETTLE_CYCLES(2), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]),
      .dut_out(dut_out[0]),
      .drv_in1(drv[0][2]), .drv_in2(drv[0][1]), .drv_in3(drv[0][0]),
      .busy(busy[0]), .done(done[0]), .table_out(tbl[0]),
      .table_valid(tv[0]), .dbg_state(st[0])
`ifdef TT3_SWEEP_COMPARE_EN
      , .expected(exp_val[0]), .match(match[0]), .mismatch_mask(mask[0])
`endif
   );

   tt3_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]),
      .dut_out(dut_out[1]),
      .drv_in1(drv[1][2]), .drv_in2(drv[1][1]), .drv_in3(drv[1][0]),
      .busy(busy[1]), .done(done[1]), .table_out(tbl[1]),
      .table_valid(tv[1]), .dbg_state(st[1])
`ifdef TT3_SWEEP_COMPARE_EN
      , .expected(exp_val[1]), .match(match[1]), .mismatch_mask(mask[1])
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One complete sweep on instance u. The expected table goes into the scoreboard
   // here and is taken out again when done is seen. Start is also pulsed during
   // RUN and during FIN, and both pulses must have no effect.
   task automatic run_sweep(input int u, input logic [7:0] tt, input int s, input logic [7:0] ev);
      int busy_cnt;
      bit got;
      logic [7:0] e;
      model_tt[u] = tt;
      exp_val[u]  = ev;
      exp_q.push_back(tt);
      start[u] = 1'b1;
      @(posedge clk); #1;
      check("valid_drop", tv[u], 0);
      check("table_clr", tbl[u], 0);
      busy_cnt = 0;
      got = 1'b0;
      for (int c = 0; c < 8 * s + 4 && !got; c++) begin
         start[u] = (c == 3);
         if (busy[u]) begin
            busy_cnt++;
            check("drv_row", drv[u], c / s);
         end
         if (done[u]) begin
            got = 1'b1;
            check("busy_len", busy_cnt, 8 * s);
            check("fin_busy", busy[u], 0);
            check("fin_drv", drv[u], 0);
            check("fin_valid", tv[u], 1);
            check("sb_size", exp_q.size(), 1);
            e = exp_q.pop_front();
            check("table", tbl[u], e);
`ifdef TT3_SWEEP_COMPARE_EN
            check("match", match[u], (e == ev));
            check("mask", mask[u], e ^ ev);
`endif
            start[u] = 1'b1;
         end
         @(posedge clk); #1;
      end
      start[u] = 1'b0;
      check("done_seen", got, 1);
      check("no_restart", busy[u], 0);
      check("done_once", done[u], 0);
      check("hold_valid", tv[u], 1);
      check("hold_table", tbl[u], tt);
      check("idle_state", st[u], 0);
   endtask

   initial begin
      int done_cnt;
      rst = 2'b11; start = 2'b00; abort = 2'b00;
      model_tt[0] = 8'h00; model_tt[1] = 8'h00;
      exp_val[0] = 8'h00;  exp_val[1] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 2'b00;
      for (int u = 0; u < 2; u++) begin
         check("rst_busy", busy[u], 0);
         check("rst_done", done[u], 0);
         check("rst_valid", tv[u], 0);
         check("rst_table", tbl[u], 0);
         check("rst_drv", drv[u], 0);
         check("rst_state", st[u], 0);
      end

      run_sweep(0, 8'hDE, 2, 8'hDE);
      run_sweep(1, 8'h01, 1, 8'h01);
      run_sweep(1, 8'h80, 1, 8'h80);
      for (int i = 0; i < 3; i++) begin
         logic [7:0] r;
         r = 8'($urandom_range(0, 255));
         run_sweep(1, r, 1, r);
      end

      // Abort in the sample cycle of row 3. Rows 0..2 of 0xDE are already
      // captured (C0), and the row-3 sample must not be stored.
      model_tt[0] = 8'hDE;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      check("abort_row", drv[0], 3);
      abort[0] = 1'b1;
      @(posedge clk); #1;
      abort[0] = 1'b0;
      check("abort_busy", busy[0], 0);
      check("abort_drv", drv[0], 0);
      check("abort_valid", tv[0], 0);
      check("abort_partial", tbl[0], 8'hC0);
      done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (done[0]) done_cnt++;
         @(posedge clk); #1;
      end
      check("abort_no_done", done_cnt, 0);

      // Reset at row 5, with start asserted at the same time. Reset wins.
      model_tt[0] = 8'hDE;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      check("rst_row", drv[0], 5);
      rst[0] = 1'b1;
      start[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      start[0] = 1'b0;
      check("mrst_busy", busy[0], 0);
      check("mrst_done", done[0], 0);
      check("mrst_valid", tv[0], 0);
      check("mrst_table", tbl[0], 0);
      check("mrst_drv", drv[0], 0);
      check("mrst_state", st[0], 0);
      done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (done[0] || busy[0]) done_cnt++;
         @(posedge clk); #1;
      end
      check("mrst_quiet", done_cnt, 0);
      run_sweep(0, 8'h5A, 2, 8'h5A);

`ifdef TT3_SWEEP_COMPARE_EN
      run_sweep(0, 8'hDE, 2, 8'hDF);
      run_sweep(0, 8'hDE, 2, 8'hDE);
`endif

      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Stops the run if the main sequence never finishes.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tt3_sweep_ctrl.md
Name: tt3_sweep_ctrl

Overview:
- Sequencer that drives a 3-input truth-table logic block (in1, in2, in3 -> out) through all 8 input rows and captures its response as an 8-bit truth-table word.
- Bit ordering matches the hex naming of the logic blocks: row 000 lands in bit 7 and row 111 in bit 0. A block implementing 0xDE therefore reads back 8'hDE.
- Sits between a host/test controller (start/abort/done handshake) and one combinational logic instance.
- Each row is held for a programmable settle time before sampling.

Parameters:
- SETTLE_CYCLES, 4: cycles each row is held on drv_in*. The DUT output is sampled on the last of them. Legal range is 1..255.
- CNT_W, 8: width of the settle counter. Must satisfy 2**CNT_W > SETTLE_CYCLES-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE
- abort  input  1  terminate an active sweep; ignored in IDLE
- dut_out  input  1  output of the logic block under control
- drv_in1  output  1  drives the logic block in1 (row bit 2, MSB)
- drv_in2  output  1  drives the logic block in2 (row bit 1)
- drv_in3  output  1  drives the logic block in3 (row bit 0, LSB)
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when a sweep completes normally
- table_out  output  8  captured truth table; bit (7-row) = dut_out sampled for that row
- table_valid  output  1  table_out holds a complete sweep

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, row=0, cnt=0, drv_in1/2/3=0, busy=0, done=0, table_out=8'h00, table_valid=0.
- Reset asserted mid-sweep: identical reset values on the next edge, and no done pulse is issued.
- States: IDLE, RUN, FIN.
- IDLE:
  - drv_in* = 000, busy=0.
  - On start=1: next state RUN, row=0, cnt=0, table_valid=0, table_out=8'h00.
- RUN:
  - busy=1; {drv_in1,drv_in2,drv_in3} = row.
  - Each cycle with cnt < SETTLE_CYCLES-1: cnt increments.
  - When cnt == SETTLE_CYCLES-1: table_out[7-row] <= dut_out and cnt <= 0.
  - After that sample, row<7 increments row; row==7 goes to FIN.
  - Busy is high for exactly 8*SETTLE_CYCLES cycles.
  - start is ignored while in RUN.
- abort in RUN:
  - Takes priority over the sample in the same cycle; that sample is discarded.
  - Next state IDLE, drv_in*=000, table_valid stays 0, done stays 0.
  - Partial table_out bits are retained but are not valid.
- FIN:
  - Lasts exactly one cycle: done=1, busy=0, table_valid=1, drv_in*=000.
  - Next state is IDLE unconditionally.
  - start during FIN is ignored.
- table_out and table_valid hold their values until the next accepted start or reset.
- SETTLE_CYCLES=1: sample every cycle, so the sweep takes 8 cycles.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro: TT3_SWEEP_COMPARE_EN
- Defined:
  - Adds input expected[7:0] and outputs match (1 bit) and mismatch_mask (8 bits).
  - expected is registered when start is accepted.
  - In FIN: mismatch_mask <= table_out ^ expected_q, where table_out includes the final row-7 sample, and match <= (that XOR == 0).
  - Both hold their values like table_valid and clear to 0 on reset or on an accepted start.
  - An aborted sweep leaves match=0.
- Undefined: the ports and the compare logic are absent, and behaviour is otherwise identical.

Test Plan:
- Model DUT as 0xDE (out=0 only for rows 010 and 111), SETTLE_CYCLES=2, pulse start -> busy high for 16 cycles, done pulse on cycle 17 after start, table_out=8'hDE, table_valid=1.
- Monitor drv_in* during sweep -> sequence 000,001,...,111, each value held 2 cycles, then 000 in FIN/IDLE.
- Model DUT as 0x01 with SETTLE_CYCLES=1 -> 8 busy cycles, table_out=8'h01; then rerun with a 0x80 model -> table_valid drops the cycle after start, final table_out=8'h80.
- Assert abort during row 3 -> busy=0 next cycle, done never pulses, table_valid=0; start pulses during RUN and FIN are ignored (no restart, no extra done).
- Assert rst at row 5 -> all outputs reach reset values on the next edge; a fresh start then completes normally with the correct table.
- With TT3_SWEEP_COMPARE_EN: DUT 0xDE and expected=8'hDE -> match=1, mask=8'h00; expected=8'hDF -> match=0, mask=8'h01.
